load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word CPU accesses onto a single-ported word memory.
// Latency (accept edge -> resp_valid): error 1, word store 2, load 3, sub-word store 4.
// Backpressure: req_ready only in IDLE; one access in flight, req_valid ignored otherwise.
//
// Ports: clk/rst (sync, active-high); req_* CPU request (valid/ready handshake);
// resp_* one-cycle completion pulse with extended load data or error flag;
// mem_* word-indexed memory strobes, read data returned the cycle after mem_read.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses
// instead of silently aligning them down.
module load_store_unit #(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state;
    logic        lat_write;
    logic        lat_unsigned;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lane;
    logic [15:0] lat_wdata;

    logic        req_err;
    logic [1:0]  eff_lane;
    logic [31:0] word_idx;
    logic [31:0] merged;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Ready is a decode of state gated by rst so it drops while rst is held
    // and rises in the very first cycle rst is low.
    always_comb begin
        req_ready = (state == IDLE) && !rst;
    end

    // Request decode: range/size checks, lane selection and word index.
    always_comb begin
        req_err  = ((req_addr >> ADDR_BITS) != 32'd0) || (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == 2'b01 && req_addr[0]) ||
            (req_size == 2'b10 && req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`endif
        // Misaligned low bits are dropped; with the trap enabled such
        // accesses never reach memory, so this only matters when it is off.
        eff_lane = req_addr[1:0];
        if (req_size == 2'b01) eff_lane[0] = 1'b0;
        if (req_size == 2'b10) eff_lane    = 2'b00;

        word_idx = '0;
        word_idx[ADDR_BITS-3:0] = req_addr[ADDR_BITS-1:2];
    end

    // Store merge into the captured word and load lane extraction/extension.
    always_comb begin
        merged = mem_read_data;
        if (lat_size == 2'b00)
            merged[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
        else
            merged[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;

        ld_byte = mem_read_data[{lat_lane, 3'b000} +: 8];
        ld_half = mem_read_data[{lat_lane[1], 4'b0000} +: 16];
        case (lat_size)
            2'b00:   ld_data = lat_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = lat_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = mem_read_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lat_write      <= 1'b0;
            lat_unsigned   <= 1'b0;
            lat_size       <= 2'b00;
            lat_lane       <= 2'b00;
            lat_wdata      <= 16'd0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_error     <= 1'b0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // rst is low here, so req_ready is high: valid alone transfers.
                    if (req_valid) begin
                        lat_write    <= req_write;
                        lat_unsigned <= req_unsigned;
                        lat_size     <= req_size;
                        lat_lane     <= eff_lane;
                        lat_wdata    <= req_wdata[15:0];
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            state      <= RESP;
                        end else if (req_write && req_size == 2'b10) begin
                            mem_address    <= word_idx;
                            mem_write_data <= req_wdata;
                            mem_write      <= 1'b1;
                            state          <= WR;
                        end else begin
                            // Loads and sub-word stores both start with a word read.
                            mem_address <= word_idx;
                            mem_read    <= 1'b1;
                            state       <= RD;
                        end
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    state    <= CAP;
                end
                CAP: begin
                    if (!lat_write) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_data;
                        state      <= RESP;
                    end else begin
                        mem_write_data <= merged;
                        mem_write      <= 1'b1;
                        state          <= WR;
                    end
                end
                WR: begin
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_error <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    load_store_unit #(.ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word memory model: registered read, write on strobe.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
        if (mem_read)  mem_read_data <= mem[mem_address[7:0]];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        int          acc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t exp_q[$];
    wr_t   wr_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples just after the active edge, pops expectations.
    int rd_seen = 0;
    int wr_seen = 0;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            rd_seen = 0;
            wr_seen = 0;
        end else begin
            chk("rd_wr_exclusive", 32'(mem_read && mem_write), 32'd0);
            if (!resp_valid)
                chk("idle_resp_zero", {resp_rdata[31:1], resp_rdata[0] | resp_error}, 32'd0);
            if (mem_read) rd_seen++;
            if (mem_write) begin
                wr_seen++;
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("write_addr", mem_address, w.addr);
                    chk("write_data", mem_write_data, w.data);
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_error", 32'(resp_error), 32'(e.err));
                    chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("mem_read_count", 32'(rd_seen), 32'(e.nrd));
                    chk("mem_write_count", 32'(wr_seen), 32'(e.nwr));
                end
                rd_seen = 0;
                wr_seen = 0;
            end
        end
    end

    // Driver: waits for ready at negedge, pushes expectations, drives one request.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit want_resp, input logic [31:0] erd, input logic eerr,
                         input int lat, input int nrd, input int nwr,
                         input logic [31:0] waddr, input logic [31:0] wdata, input int hold);
        resp_t e;
        wr_t   x;
        int    n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        e.rdata = erd; e.err = eerr; e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.acc = cyc;
        if (want_resp) exp_q.push_back(e);
        if (nwr != 0) begin
            x.addr = waddr; x.data = wdata;
            wr_q.push_back(x);
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(negedge clk);
        repeat (hold) @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Word stores: preload and the basic store path.
        issue(1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 1, 32'h0, 0, 2, 0, 1, 32'd4,   32'hDEADBEEF, 0);
        issue(1, 2'b10, 0, 32'h014, 32'hA5A5A5A5, 1, 32'h0, 0, 2, 0, 1, 32'd5,   32'hA5A5A5A5, 0);
        issue(1, 2'b10, 0, 32'h3FC, 32'h80123456, 1, 32'h0, 0, 2, 0, 1, 32'd255, 32'h80123456, 0);
        issue(1, 2'b10, 0, 32'h020, 32'h00000000, 1, 32'h0, 0, 2, 0, 1, 32'd8,   32'h00000000, 0);

        // Loads with extension; first one holds req_valid past acceptance.
        issue(0, 2'b00, 0, 32'h013, 32'h0, 1, 32'hFFFFFFDE, 0, 3, 1, 0, 0, 0, 1);
        issue(0, 2'b00, 1, 32'h013, 32'h0, 1, 32'h000000DE, 0, 3, 1, 0, 0, 0, 0);
        issue(0, 2'b01, 0, 32'h012, 32'h0, 1, 32'hFFFFDEAD, 0, 3, 1, 0, 0, 0, 0);
        issue(0, 2'b01, 1, 32'h012, 32'h0, 1, 32'h0000DEAD, 0, 3, 1, 0, 0, 0, 0);
        issue(0, 2'b00, 0, 32'h3FF, 32'h0, 1, 32'hFFFFFF80, 0, 3, 1, 0, 0, 0, 0);
        issue(0, 2'b00, 1, 32'h3FE, 32'h0, 1, 32'h00000012, 0, 3, 1, 0, 0, 0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        issue(0, 2'b01, 0, 32'h011, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        issue(0, 2'b10, 0, 32'h013, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
`else
        issue(0, 2'b01, 0, 32'h011, 32'h0, 1, 32'hFFFFBEEF, 0, 3, 1, 0, 0, 0, 0);
        issue(0, 2'b10, 0, 32'h013, 32'h0, 1, 32'hDEADBEEF, 0, 3, 1, 0, 0, 0, 0);
`endif

        // Sub-word stores: only the addressed lane changes.
        issue(1, 2'b00, 0, 32'h011, 32'hFFFFFF55, 1, 32'h0, 0, 4, 1, 1, 32'd4, 32'hDEAD55EF, 0);
        issue(0, 2'b10, 1, 32'h010, 32'h0, 1, 32'hDEAD55EF, 0, 3, 1, 0, 0, 0, 0);
        issue(1, 2'b01, 0, 32'h016, 32'hABCD1234, 1, 32'h0, 0, 4, 1, 1, 32'd5, 32'h1234A5A5, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1, 2'b01, 0, 32'h017, 32'h00007777, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
`else
        issue(1, 2'b01, 0, 32'h017, 32'h00007777, 1, 32'h0, 0, 4, 1, 1, 32'd5, 32'h7777A5A5, 0);
`endif

        // Error paths: out of range, illegal size, high address bit on a store.
        issue(0, 2'b01, 0, 32'h402, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        issue(0, 2'b11, 0, 32'h010, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        issue(1, 2'b10, 0, 32'h80000010, 32'h12345678, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);

        // Reset while a sub-word store sits in WR: no response, ready right after.
        issue(1, 2'b00, 0, 32'h021, 32'h00000077, 0, 32'h0, 0, 0, 1, 1, 32'd8, 32'h00007700, 0);
        begin
            int n = 0;
            while (!mem_write && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("abort_reach_wr", 32'(mem_write), 32'd1);
            rst = 1'b1;
            @(negedge clk);
            chk("abort_no_write", 32'(mem_write), 32'd0);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
            chk("abort_ready_low", 32'(req_ready), 32'd0);
            rst = 1'b0;
            @(negedge clk);
            chk("abort_ready_high", 32'(req_ready), 32'd1);
        end

`ifdef LSU_MISALIGN_TRAP_EN
        issue(0, 2'b10, 0, 32'h014, 32'h0, 1, 32'h1234A5A5, 0, 3, 1, 0, 0, 0, 0);
`else
        issue(0, 2'b10, 0, 32'h014, 32'h0, 1, 32'h7777A5A5, 0, 3, 1, 0, 0, 0, 0);
`endif

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            repeat (3) @(negedge clk);
        end
        chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
